// File: rtl/ads1292_pkg.sv
// Shared types and constants for the ADS1292 frame reader.
// FSM encoding, device opcodes and frame field widths.
package ads1292_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND,
    WAIT_RX,
    CS_HOLD
  } state_t;

  localparam logic [7:0] OP_RDATAC = 8'h10;
  localparam logic [7:0] OP_SDATAC = 8'h11;
  localparam logic [7:0] OP_RDATA  = 8'h12;

  localparam int FIELD_W = 24;
  localparam int FRAME_W = 3 * FIELD_W;

endpackage

// File: rtl/sync_falling_edge.sv
// 2-flop synchronizer plus edge-detect flop; o_FALL pulses one cycle per 1->0.
// Ports: i_CLK, i_RSTN (async low), i_ASYNC (raw pin), o_FALL (pulse).
module sync_falling_edge
  import ads1292_pkg::*;
(
  input  logic i_CLK,
  input  logic i_RSTN,
  input  logic i_ASYNC,
  output logic o_FALL
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= i_ASYNC;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign o_FALL = prev & ~sync2;

endmodule

// File: rtl/ads1292_frame_reader.sv
// Reads one RDATAC frame per DRDY fall by driving a byte-level SPI master.
// Ports: i_CLK/i_RSTN, i_ENABLE, i_DRDY_N, o_CS_N, SPI TX/RX, frame outputs, o_BUSY, o_OVERRUN.
module ads1292_frame_reader
  import ads1292_pkg::*;
#(
  parameter int         N_BYTES       = 9,
  parameter int         CS_SETUP_CLKS = 4,
  parameter int         CS_HOLD_CLKS  = 16,
  parameter logic [7:0] DUMMY_BYTE    = 8'h00
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic        i_ENABLE,
  input  logic        i_DRDY_N,
  output logic        o_CS_N,
  output logic [7:0]  o_TX_Byte,
  output logic        o_TX_DV,
  input  logic        i_TX_Ready,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic [23:0] o_STATUS,
  output logic [23:0] o_CH1,
  output logic [23:0] o_CH2,
  output logic        o_FRAME_DV,
  output logic        o_BUSY,
  output logic        o_OVERRUN
);

  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP_CLKS - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD_CLKS - 1);
  localparam logic [3:0] LAST     = 4'(N_BYTES - 1);

  state_t             state;
  logic               drdy_fall;
  logic [3:0]         byte_cnt;
  logic [7:0]         cnt;
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] frame;

  sync_falling_edge u_drdy (
    .i_CLK   (i_CLK),
    .i_RSTN  (i_RSTN),
    .i_ASYNC (i_DRDY_N),
    .o_FALL  (drdy_fall)
  );

  // Frame as it looks once the byte on i_RX_Byte is shifted in
  assign frame  = {sr[FRAME_W-9:0], i_RX_Byte};
  assign o_BUSY = (state != IDLE);

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state      <= IDLE;
      o_CS_N     <= 1'b1;
      o_TX_DV    <= 1'b0;
      o_TX_Byte  <= 8'h00;
      o_STATUS   <= '0;
      o_CH1      <= '0;
      o_CH2      <= '0;
      o_FRAME_DV <= 1'b0;
      o_OVERRUN  <= 1'b0;
      byte_cnt   <= '0;
      cnt        <= '0;
      sr         <= '0;
    end else begin
      o_TX_DV    <= 1'b0;
      o_FRAME_DV <= 1'b0;
      o_OVERRUN  <= drdy_fall && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (drdy_fall && i_ENABLE) begin
            state    <= CS_SETUP;
            o_CS_N   <= 1'b0;
            cnt      <= SETUP_LD;
            byte_cnt <= '0;
          end
        end
        CS_SETUP: begin
          // The zero-count cycle already acts as SEND so the first
          // pulse lands exactly CS_SETUP_CLKS after CS falls.
          if (cnt != 0) begin
            cnt <= cnt - 8'd1;
          end else if (i_TX_Ready) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= DUMMY_BYTE;
            state     <= WAIT_RX;
          end else begin
            state <= SEND;
          end
        end
        SEND: begin
          if (i_TX_Ready) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= DUMMY_BYTE;
            state     <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          // i_TX_Ready is stale right after a pulse; only RX_DV matters
          if (i_RX_DV) begin
            sr       <= frame;
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == LAST) begin
              state      <= CS_HOLD;
              cnt        <= HOLD_LD;
              o_STATUS   <= frame[71:48];
              o_CH1      <= frame[47:24];
              o_CH2      <= frame[23:0];
              o_FRAME_DV <= 1'b1;
            end else begin
              state <= SEND;
            end
          end
        end
        CS_HOLD: begin
          if (cnt == 0) begin
            o_CS_N <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
